// File: rtl/uart_tx_if.sv
// Upstream beat handshake into uart_tx: valid/ready with a W_IN-bit payload.
interface uart_tx_if #(
    parameter int W_IN = 24
);
    logic            s_valid;
    logic [W_IN-1:0] s_data;
    logic            s_ready;

    modport master (output s_valid, s_data, input s_ready);
    modport slave  (input s_valid, s_data, output s_ready);
endinterface

// File: rtl/uart_tx.sv
// Serialises each accepted W_IN-bit beat as NUM_WORDS back-to-back UART frames,
// word 0 first, data bits LSB first and inverted on the line.
module uart_tx #(
    parameter int CLOCKS_PER_PULSE = 4,
    parameter int BITS_PER_WORD    = 8,
    parameter int W_IN             = 24
) (
    input  logic      clk,
    input  logic      rstn,
    uart_tx_if.slave  up,
    output logic      tx,
    output logic      busy
);
    localparam int NUM_WORDS = W_IN / BITS_PER_WORD;
    localparam int CW = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
    localparam int BW = (BITS_PER_WORD > 1) ? $clog2(BITS_PER_WORD) : 1;
    localparam int WW = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;

    localparam logic [CW-1:0] CLK_LAST  = CW'(CLOCKS_PER_PULSE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(BITS_PER_WORD - 1);
    localparam logic [WW-1:0] WORD_LAST = WW'(NUM_WORDS - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    generate
        if ((W_IN % BITS_PER_WORD) != 0 || CLOCKS_PER_PULSE < 2) begin : g_bad_params
            $error("uart_tx: W_IN must be a multiple of BITS_PER_WORD and CLOCKS_PER_PULSE must be >= 2");
        end
    endgenerate

    logic [1:0]      state;
    logic [CW-1:0]   clk_cnt;
    logic [BW-1:0]   bit_cnt;
    logic [WW-1:0]   word_cnt;
    logic [W_IN-1:0] shift;
    logic [W_IN-1:0] shifted;
    logic            pulse_end;

    // The next data bit sits at shifted[0]; the register advances as each bit is launched.
    assign shifted   = shift >> 1;
    assign pulse_end = (clk_cnt == CLK_LAST);

    // NOTE: every register here uses non-blocking assignment so all state updates
    // see the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            // NOTE: the shift register is reset along with the control state so an
            // aborted beat leaves no residue for the next one.
            state      <= IDLE;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
            word_cnt   <= '0;
            shift      <= '0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            up.s_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (up.s_valid && up.s_ready) begin
                        state      <= START;
                        shift      <= up.s_data;
                        clk_cnt    <= '0;
                        tx         <= 1'b0;
                        busy       <= 1'b1;
                        up.s_ready <= 1'b0;
                    end
                end

                START: begin
                    if (pulse_end) begin
                        clk_cnt <= '0;
                        state   <= DATA;
                        tx      <= ~shift[0];
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                DATA: begin
                    if (pulse_end) begin
                        clk_cnt <= '0;
                        shift   <= shifted;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= STOP;
                            tx      <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= ~shifted[0];
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                STOP: begin
                    if (pulse_end) begin
                        clk_cnt <= '0;
                        if (word_cnt == WORD_LAST) begin
                            // Last stop bit ends here: ready again on this same edge.
                            word_cnt   <= '0;
                            state      <= IDLE;
                            tx         <= 1'b1;
                            busy       <= 1'b0;
                            up.s_ready <= 1'b1;
                        end else begin
                            word_cnt <= word_cnt + 1'b1;
                            state    <= START;
                            tx       <= 1'b0;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx.sv
// Self-checking bench for uart_tx: waveform-level reference, serial decoder scoreboard.
module tb_uart_tx;
    localparam int CPP      = 4;
    localparam int BPW      = 8;
    localparam int W        = 16;
    localparam int NW       = W / BPW;
    localparam int BEAT_CYC = NW * (BPW + 2) * CPP;

    localparam int QUIET    = 0;
    localparam int SCRAMBLE = 1;
    localparam int HOLD     = 2;

    logic clk;
    logic rstn;
    logic tx;
    logic busy;
    logic rx_en;
    int   checks;
    int   failures;
    logic [W-1:0] exp_q[$];

    uart_tx_if #(.W_IN(W)) bus ();

    uart_tx #(
        .CLOCKS_PER_PULSE(CPP),
        .BITS_PER_WORD   (BPW),
        .W_IN            (W)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .up  (bus),
        .tx  (tx),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Line level expected on each cycle of a beat, built frame by frame from the data.
    function automatic logic [BEAT_CYC-1:0] expect_wave(input logic [W-1:0] d);
        logic [BEAT_CYC-1:0] w;
        logic b;
        int k;
        k = 0;
        w = '0;
        for (int f = 0; f < NW; f++) begin
            for (int i = 0; i < BPW + 2; i++) begin
                if (i == 0)            b = 1'b0;
                else if (i == BPW + 1) b = 1'b1;
                else                   b = ~d[f*BPW + i - 1];
                for (int c = 0; c < CPP; c++) begin
                    w[k] = b;
                    k++;
                end
            end
        end
        return w;
    endfunction

    // Called at the negedge right after the accepting edge has been set up; samples
    // the whole beat plus the following cycle, when the block must be idle and ready.
    task automatic capture_beat(input string tag, input logic [W-1:0] d,
                                input int mode, input logic [W-1:0] nxt);
        logic [BEAT_CYC-1:0] obs;
        logic [BEAT_CYC-1:0] exp_w;
        int ready_hi;
        int busy_lo;
        exp_w    = expect_wave(d);
        obs      = '0;
        ready_hi = 0;
        busy_lo  = 0;
        for (int i = 0; i < BEAT_CYC; i++) begin
            @(negedge clk);
            obs[i]   = tx;
            ready_hi += int'(bus.s_ready);
            busy_lo  += int'(!busy);
            case (mode)
                SCRAMBLE: begin
                    bus.s_valid = 1'($urandom_range(0, 1));
                    bus.s_data  = W'($urandom);
                end
                HOLD: begin
                    bus.s_valid = 1'b1;
                    bus.s_data  = nxt;
                end
                default: begin
                    bus.s_valid = 1'b0;
                    bus.s_data  = W'($urandom);
                end
            endcase
        end
        check({tag, "_tx"}, obs, exp_w);
        check({tag, "_ready_low"}, ready_hi, 0);
        check({tag, "_busy_high"}, busy_lo, 0);
        @(negedge clk);
        check({tag, "_end_tx"}, tx, 1'b1);
        check({tag, "_end_ready"}, bus.s_ready, 1'b1);
        check({tag, "_end_busy"}, busy, 1'b0);
        if (mode != HOLD) bus.s_valid = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [W-1:0] d,
                             input int mode, input logic [W-1:0] nxt);
        @(negedge clk);
        check({tag, "_ready_before"}, bus.s_ready, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = d;
        if (rx_en) exp_q.push_back(d);
        capture_beat(tag, d, mode, nxt);
    endtask

    task automatic idle_check(input string tag, input int n);
        int bad;
        bad = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || bus.s_ready !== 1'b1) bad++;
        end
        check(tag, bad, 0);
    endtask

    // Behavioural receiver: mid-bit sampling, reassembles beats and scores them in order.
    initial begin : rx_model
        logic [W-1:0]   beat;
        logic [BPW-1:0] w;
        int widx;
        widx = 0;
        beat = '0;
        w    = '0;
        forever begin
            @(negedge clk);
            if (rx_en && tx === 1'b0) begin
                repeat (CPP / 2) @(negedge clk);
                for (int b = 0; b < BPW; b++) begin
                    repeat (CPP) @(negedge clk);
                    w[b] = ~tx;
                end
                repeat (CPP) @(negedge clk);
                check("rx_stop", tx, 1'b1);
                beat[widx*BPW +: BPW] = w;
                if (widx == NW - 1) begin
                    widx = 0;
                    check("rx_queue", exp_q.size(), 1);
                    if (exp_q.size() > 0) check("rx_data", beat, exp_q.pop_front());
                end else begin
                    widx++;
                end
            end
        end
    end

    initial begin
        logic [BEAT_CYC-1:0] wave;
        checks      = 0;
        failures    = 0;
        rx_en       = 1'b0;
        rstn        = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_data  = '0;

        #3 rstn = 1'b0;
        #1;
        check("reset_tx", tx, 1'b1);
        check("reset_ready", bus.s_ready, 1'b1);
        check("reset_busy", busy, 1'b0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        idle_check("idle_after_reset", 5);

        send_beat("a53c", 16'hA53C, QUIET, '0);
        idle_check("idle_after_a53c", 3);

        send_beat("scramble", W'($urandom), SCRAMBLE, '0);
        idle_check("no_extra_beat", 20);

        send_beat("b2b_first", 16'h0001, HOLD, 16'hFFFF);
        capture_beat("b2b_second", 16'hFFFF, QUIET, '0);
        idle_check("idle_after_b2b", 5);

        // Abort in the middle of word 0 data bit 1 (line low for 0x5A5A there).
        @(negedge clk);
        bus.s_valid = 1'b1;
        bus.s_data  = 16'h5A5A;
        @(negedge clk);
        bus.s_valid = 1'b0;
        wave = expect_wave(16'h5A5A);
        repeat (9) @(negedge clk);
        check("pre_reset_tx", tx, wave[9]);
        #2 rstn = 1'b0;
        #1;
        check("mid_reset_tx", tx, 1'b1);
        check("mid_reset_ready", bus.s_ready, 1'b1);
        check("mid_reset_busy", busy, 1'b0);
        @(negedge clk);
        rstn = 1'b1;
        idle_check("abort_no_frames", 100);
        send_beat("after_reset", 16'h1234, QUIET, '0);

        rx_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            send_beat("rand", W'($urandom), QUIET, '0);
            idle_check("rand_gap", $urandom_range(1, 20));
        end
        repeat (10) @(negedge clk);
        rx_en = 1'b0;
        check("rx_drained", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLOCKS_PER_PULSE, default 4: clk cycles per serial bit.
REQ-002 Parameter BITS_PER_WORD, default 8: data bits per serial frame.
REQ-003 Parameter W_IN, default 24: width of the parallel input beat; W_IN % BITS_PER_WORD == 0 and CLOCKS_PER_PULSE >= 2 SHALL be enforced by an elaboration-time check.
REQ-004 Localparam NUM_WORDS = W_IN/BITS_PER_WORD: frames per beat.
REQ-005 clk  input  1  clock, all logic on rising edge.
REQ-006 rstn  input  1  reset, asynchronous, active-low.
REQ-007 s_valid  input  1  upstream beat valid.
REQ-008 s_data  input  W_IN  upstream beat payload.
REQ-009 s_ready  output  1  block can accept a beat; registered.
REQ-010 tx  output  1  serial line, idle high; registered.
REQ-011 busy  output  1  high while any frame of a beat is being sent; registered.

Function
REQ-012 Handshake: a beat SHALL be accepted on a rising edge where s_valid && s_ready; s_valid with s_ready low SHALL have no effect.
REQ-013 s_ready SHALL be high only in IDLE; it SHALL fall on the accepting edge.
REQ-014 On acceptance s_data SHALL be captured into an internal shift register; later changes to s_data SHALL have no effect on the beat in flight.
REQ-015 States: IDLE, START, DATA, STOP.
REQ-016 IDLE -> START on acceptance; START -> DATA after CLOCKS_PER_PULSE cycles; DATA -> STOP after BITS_PER_WORD bits; STOP -> START if more frames remain in the beat, else STOP -> IDLE.
REQ-017 Each bit SHALL be held on tx for exactly CLOCKS_PER_PULSE cycles, via a clock counter of width $clog2(CLOCKS_PER_PULSE) that wraps to 0 at CLOCKS_PER_PULSE-1.
REQ-018 Frame format: start bit 0, then BITS_PER_WORD data bits LSB first, each data bit INVERTED, then one stop bit 1 (line polarity matches uart_rx).
REQ-019 Frame order: word 0 (s_data[BITS_PER_WORD-1:0]) first, then ascending words; frames are back-to-back with no idle gap.
REQ-020 tx SHALL drive the start bit from the accepting edge; one beat occupies exactly NUM_WORDS*(BITS_PER_WORD+2)*CLOCKS_PER_PULSE cycles.
REQ-021 s_ready SHALL rise, and busy SHALL fall, on the edge that ends the last stop bit; a beat offered then SHALL be accepted one cycle later, giving exactly one idle-high tx cycle between beats.
REQ-022 Bit counter SHALL wrap at BITS_PER_WORD-1 and word counter at NUM_WORDS-1, both returning to 0 for the next beat.
REQ-023 busy SHALL equal (state != IDLE).

Reset
REQ-024 rstn low SHALL force, asynchronously: tx=1, s_ready=1, busy=0, state IDLE, all counters and the shift register 0.
REQ-025 Reset mid-beat SHALL abort the beat with no further frames; the first beat after rstn rises SHALL be sent completely and correctly.

Verification (CLOCKS_PER_PULSE=4, BITS_PER_WORD=8, W_IN=16)
REQ-026 Reset: rstn=0 at any time -> tx=1, s_ready=1, busy=0 within the same cycle.
REQ-027 Single beat s_data=16'hA53C -> tx bits, 4 cycles each: 0,1,1,0,0,0,0,1,1,1 then 0,0,1,0,1,1,0,1,0,1; s_ready low for 80 cycles.
REQ-028 s_valid held high with two beats 16'h0001, 16'hFFFF -> second start bit follows first beat's final stop bit after exactly one idle-high cycle; s_ready high for exactly one cycle in between.
REQ-029 s_data changed every cycle while busy, plus s_valid pulses with s_ready low -> serial output identical to the originally captured beat; no extra beats.
REQ-030 rstn pulsed low during word-0 DATA -> tx=1 immediately, no remaining frames; a following beat 16'h1234 is sent correctly.
REQ-031 Loopback into uart_rx (same parameters, W_OUT=16) with 10 random beats and random 1-20 cycle gaps -> every uart_rx m_data equals the s_data sent, in order.
